// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment scanner
//
// Purpose: segment type, blank pattern and the active-low hex glyph table
//          used by hex_to_seg and seven_seg_scan.
// Ports:   none (package).

package seven_seg_pkg;

   // Segments a..g on bits 0..6, active low.
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Glyphs for 0..F (b and d lowercase so they differ from 8 and 0).
   localparam seg_t HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to seven-segment lookup
//
// Purpose: maps one 4-bit value to its active-low segment pattern.
// Ports:   nibble - hex digit to show
//          seg    - segments a..g on bits 0..6, active low

module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed hex display driver with register select
//
// Purpose: picks one of NUM_REGS registers (manual sel or auto-cycling),
//          snapshots it once per frame and scans it as DATA_W/4 hex digits
//          on common-anode displays, with one blank cycle between digits.
//          Build option SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking.
// Ports:   clk, rst_n - clock, asynchronous active-low reset
//          regs_flat  - register k at bits [k*DATA_W +: DATA_W]
//          sel        - manual register index (out of range selects 0)
//          auto_en    - 1 = advance the index every AUTO_DIV frames
//          freeze     - 1 = hold index, snapshot and frame counter
//          seg, dp    - segments a..g and decimal point, active low
//          an         - digit enables, active low, an[0] = low nibble
//          cur_idx    - index currently displayed
//          cur_val    - snapshot currently displayed

module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter  int NUM_REGS = 16,
   parameter  int DATA_W   = 16,
   parameter  int SCAN_DIV = 50000,
   parameter  int AUTO_DIV = 256,
   localparam int SELW     = $clog2(NUM_REGS),
   localparam int DIGITS   = DATA_W / 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
   input  logic [SELW-1:0]            sel,
   input  logic                       auto_en,
   input  logic                       freeze,
   output seg_t                       seg,
   output logic                       dp,
   output logic [DIGITS-1:0]          an,
   output logic [SELW-1:0]            cur_idx,
   output logic [DATA_W-1:0]          cur_val
);

   localparam int CW  = $clog2(SCAN_DIV);
   localparam int FW  = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam int DPW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0]   FCNT_LAST = FW'(AUTO_DIV - 1);
   localparam logic [DPW-1:0]  DPTR_LAST = DPW'(DIGITS - 1);
   localparam logic [SELW-1:0] IDX_LAST  = SELW'(NUM_REGS - 1);

   logic [CW-1:0]     cnt;
   logic [DPW-1:0]    dptr;
   logic [FW-1:0]     fcnt;
   logic [FW-1:0]     next_fcnt;
   logic [SELW-1:0]   next_idx;
   logic              tick;
   logic              frame_start;
   logic              lz_blank;
   logic [3:0]        cur_nib;
   seg_t              dec_seg;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [3:0]        nib  [DIGITS];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[g] = regs_flat[g*DATA_W +: DATA_W];
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_nib
      assign nib[g] = cur_val[g*4 +: 4];
   end

   assign tick        = (cnt == CNT_LAST);
   assign frame_start = tick && (dptr == DPTR_LAST);

   // Index the next frame will show; the snapshot is read from the same
   // index in the same cycle so a frame never mixes two register values.
   always_comb begin
      next_idx  = cur_idx;
      next_fcnt = fcnt;
      if (!auto_en) begin
         next_fcnt = '0;
         next_idx  = (32'(sel) >= NUM_REGS) ? '0 : sel;
      end else if (fcnt == FCNT_LAST) begin
         next_fcnt = '0;
         next_idx  = (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;
      end else begin
         next_fcnt = fcnt + 1'b1;
      end
   end

   // Counter is held at zero in manual mode, so auto-cycling always starts
   // a full AUTO_DIV period from the index that was on display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         dptr    <= '0;
         fcnt    <= '0;
         cur_idx <= '0;
         cur_val <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            dptr <= (dptr == DPTR_LAST) ? '0 : dptr + 1'b1;
         end
         if (!auto_en) begin
            fcnt <= '0;
         end else if (frame_start && !freeze) begin
            fcnt <= next_fcnt;
         end
         if (frame_start && !freeze) begin
            cur_idx <= next_idx;
            cur_val <= regs[next_idx];
         end
      end
   end

   assign cur_nib = nib[dptr];

   hex_to_seg u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

`ifdef SEVEN_SEG_LZ_BLANK_EN
   // Most significant nonzero digit; digit 0 is never blanked.
   logic [DPW-1:0] msd;

   always_comb begin
      msd = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (nib[i] != 4'h0) begin
            msd = DPW'(i);
         end
      end
   end

   assign lz_blank = (dptr > msd);
`else
   assign lz_blank = 1'b0;
`endif

   // The tick cycle blanks all anodes for one clock before the next digit
   // is enabled, so the previous digit's segments never ghost onto it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_BLANK;
         dp  <= 1'b1;
         an  <= '1;
      end else if (tick) begin
         seg <= SEG_BLANK;
         dp  <= 1'b1;
         an  <= '1;
      end else begin
         seg <= lz_blank ? SEG_BLANK : dec_seg;
         dp  <= !(auto_en && (dptr == DPTR_LAST));
         an  <= ~(DIGITS'(1) << dptr);
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan

module tb_seven_seg_scan;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } rec_t;

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] val;
      logic [3:0]  sel_b;
      logic [3:0]  idx_b;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic [255:0] regs_flat_a;
   logic [191:0] regs_flat_b;
   logic [15:0]  regs_a [16];
   logic [15:0]  regs_b [12];
   logic [3:0]   sel;
   logic [3:0]   sel_b;
   logic         auto_en;
   logic         freeze;
   logic [6:0]   seg;
   logic         dp;
   logic [3:0]   an;
   logic [3:0]   cur_idx;
   logic [15:0]  cur_val;
   logic [6:0]   seg_b;
   logic         dp_b;
   logic [3:0]   an_b;
   logic [3:0]   cur_idx_b;
   logic [15:0]  cur_val_b;

   int   tests = 0;
   int   fails = 0;
   rec_t sb [$];
   rec_t got;
   rec_t exp_r;
   logic [3:0]  prev_an = 4'hF;
   logic [15:0] old_val;
   vec_t vecs [6];
   logic [3:0]  auto_seq [6];
   logic [6:0]  seg_tbl [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   seven_seg_scan #(.NUM_REGS(16), .DATA_W(16), .SCAN_DIV(4), .AUTO_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .regs_flat(regs_flat_a), .sel(sel),
      .auto_en(auto_en), .freeze(freeze), .seg(seg), .dp(dp), .an(an),
      .cur_idx(cur_idx), .cur_val(cur_val)
   );

   // Non-power-of-two register count for out-of-range select checks.
   seven_seg_scan #(.NUM_REGS(12), .DATA_W(16), .SCAN_DIV(4), .AUTO_DIV(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .regs_flat(regs_flat_b), .sel(sel_b),
      .auto_en(1'b0), .freeze(1'b0), .seg(seg_b), .dp(dp_b), .an(an_b),
      .cur_idx(cur_idx_b), .cur_val(cur_val_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 16; k++) regs_flat_a[k*16 +: 16] = regs_a[k];
      for (int k = 0; k < 12; k++) regs_flat_b[k*16 +: 16] = regs_b[k];
   end

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
      logic [3:0] n;
      int msd;
      msd = 0;
      for (int i = 1; i < 4; i++) if (4'(v >> (4*i)) != 4'h0) msd = i;
      n = 4'(v >> (4*d));
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (d > msd) return 7'h7F;
`endif
      return seg_tbl[n];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [15:0] v, input logic auto_on);
      rec_t r;
      for (int d = 0; d < 4; d++) begin
         r.an  = ~(4'b0001 << d);
         r.seg = exp_seg(v, d);
         r.dp  = !(auto_on && d == 3);
         sb.push_back(r);
      end
   endtask

   // Returns on the blank cycle that opens a new frame.
   task automatic wait_frame();
      int n;
      n = 0;
      while (an !== 4'h7 && n < 200) begin @(negedge clk); n++; end
      while (an !== 4'hF && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL wait_frame timeout an=%h required=F", an);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   // Each digit slot begins when an leaves the all-ones blank state.
   always @(negedge clk) begin
      if (an !== 4'hF && an !== prev_an) begin
         tests++;
         if (prev_an !== 4'hF) begin
            fails++;
            $display("FAIL ghost an=%h after an=%h required blank F between", an, prev_an);
         end
         if (sb.size() != 0) begin
            exp_r = sb.pop_front();
            got   = '{an: an, seg: seg, dp: dp};
            tests++;
            if (got !== exp_r) begin
               fails++;
               $display("FAIL slot an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                        got.an, got.seg, got.dp, exp_r.an, exp_r.seg, exp_r.dp);
            end
         end
      end
      prev_an = an;
   end

   initial begin
      vecs[0] = '{sel: 4'd3,  val: 16'h1A2F, sel_b: 4'd13, idx_b: 4'd0};
      vecs[1] = '{sel: 4'd1,  val: 16'h3746, sel_b: 4'd11, idx_b: 4'd11};
      vecs[2] = '{sel: 4'd15, val: 16'h0070, sel_b: 4'd15, idx_b: 4'd0};
      vecs[3] = '{sel: 4'd7,  val: 16'h89AB, sel_b: 4'd12, idx_b: 4'd0};
      vecs[4] = '{sel: 4'd9,  val: 16'hCDE5, sel_b: 4'd5,  idx_b: 4'd5};
      vecs[5] = '{sel: 4'd0,  val: 16'h0000, sel_b: 4'd0,  idx_b: 4'd0};
      auto_seq = '{4'd14, 4'd15, 4'd15, 4'd0, 4'd0, 4'd1};

      for (int k = 0; k < 16; k++) regs_a[k] = 16'(32'h1111 * k);
      for (int k = 0; k < 12; k++) regs_b[k] = 16'hB000 + 16'(k);
      rst_n = 1'b0; sel = 4'd0; sel_b = 4'd0; auto_en = 1'b0; freeze = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_cur_val", 32'(cur_val), 32'h0);
      chk("rst_cur_idx", 32'(cur_idx), 32'h0);
      rst_n = 1'b1;

      // Manual select table
      for (int i = 0; i < 6; i++) begin
         regs_a[vecs[i].sel] = vecs[i].val;
         sel   = vecs[i].sel;
         sel_b = vecs[i].sel_b;
         wait_frame();
         chk("man_cur_idx", 32'(cur_idx), 32'(vecs[i].sel));
         chk("man_cur_val", 32'(cur_val), 32'(vecs[i].val));
         chk("oor_cur_idx", 32'(cur_idx_b), 32'(vecs[i].idx_b));
         chk("oor_cur_val", 32'(cur_val_b), 32'(regs_b[vecs[i].idx_b]));
         push_frame(vecs[i].val, 1'b0);
         drain();
      end

      // Frame coherency: mid-frame register change shows next frame only
      regs_a[2] = 16'h4455;
      sel = 4'd2;
      wait_frame();
      push_frame(16'h4455, 1'b0);
      repeat (6) @(negedge clk);
      regs_a[2] = 16'h9876;
      drain();
      wait_frame();
      chk("coh_cur_val", 32'(cur_val), 32'h9876);
      push_frame(16'h9876, 1'b0);
      drain();

      // Auto-cycle from index 14 with wrap
      sel = 4'd14;
      wait_frame();
      chk("auto_start_idx", 32'(cur_idx), 32'd14);
      auto_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_frame();
         chk("auto_cur_idx", 32'(cur_idx), 32'(auto_seq[i]));
         chk("auto_cur_val", 32'(cur_val), 32'(regs_a[auto_seq[i]]));
         push_frame(regs_a[auto_seq[i]], 1'b1);
         drain();
      end
      auto_en = 1'b0;

      // Freeze holds index and snapshot across frames
      sel = 4'd5;
      wait_frame();
      chk("frz_pre_idx", 32'(cur_idx), 32'd5);
      old_val = regs_a[5];
      repeat (6) @(negedge clk);
      freeze = 1'b1;
      sel = 4'd8;
      regs_a[5] = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         wait_frame();
         chk("frz_cur_idx", 32'(cur_idx), 32'd5);
         chk("frz_cur_val", 32'(cur_val), 32'(old_val));
         push_frame(old_val, 1'b0);
         drain();
      end
      freeze = 1'b0;
      wait_frame();
      chk("unfrz_cur_idx", 32'(cur_idx), 32'd8);
      chk("unfrz_cur_val", 32'(cur_val), 32'(regs_a[8]));

      // Asynchronous reset mid-scan
      wait_frame();
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_seg", 32'(seg), 32'h7F);
      chk("async_an", 32'(an), 32'hF);
      chk("async_dp", 32'(dp), 32'h1);
      chk("async_cur_val", 32'(cur_val), 32'h0);
      chk("async_cur_idx", 32'(cur_idx), 32'h0);
      repeat (2) @(negedge clk);
      push_frame(16'h0000, 1'b0);
      rst_n = 1'b1;
      drain();
      wait_frame();
      chk("post_rst_idx", 32'(cur_idx), 32'd8);
      chk("post_rst_val", 32'(cur_val), 32'(regs_a[8]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
